// File: rtl/ddr_port_sram.sv
// ddr_port_sram -- word-wide SRAM behind the native DDR port (wr_*/rd_* handshake).
// Stands in for a DDR controller: fixed write/read latency, busy back-pressure,
// one outstanding command per direction, write and read sides independent.
//
// Ports
//   clk, rst_n        clock; reset is asynchronous and active-HIGH (rst_n=1 resets)
//   wr_addr/_addr_en  write byte address + strobe (accepted only when wr_busy=0)
//   wr_data/_datamask write word + byte mask (mask bit 1 = byte not written)
//   wr_en             write data strobe
//   wr_busy, wr_ack   write side busy; 1-cycle pulse after the array commit
//   rd_addr/_addr_en  read byte address + strobe (accepted only when rd_busy=0)
//   rd_en             read issue strobe
//   rd_busy, rd_ack   read side busy; 1-cycle pulse the cycle after issue
//   rd_data, rd_valid read word (held between reads); 1-cycle valid pulse
//
// Optional feature: define DDR_PORT_SRAM_REFRESH_EN to model periodic refresh
// (busy forced high, no new addresses accepted while it runs).
//
// The array has no reset and keeps its contents across rst_n; it relies on the
// simulator / FPGA configuration for its zero power-up state.
module ddr_port_sram #(
  parameter int DATA_WIDTH  = 128,
  parameter int DM_WIDTH    = 16,   // must equal DATA_WIDTH/8
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024, // power of 2
  parameter int WR_LATENCY  = 2,    // >= 1
  parameter int RD_LATENCY  = 4     // >= 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_addr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DM_WIDTH-1:0]   wr_datamask,
  input  logic                  wr_en,
  output logic                  wr_busy,
  output logic                  wr_ack,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_addr_en,
  input  logic                  rd_en,
  output logic                  rd_busy,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int OFF_W = $clog2(DM_WIDTH);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int WC_W  = $clog2(WR_LATENCY + 1);
  localparam int RC_W  = $clog2(RD_LATENCY + 1);
  localparam logic [WC_W-1:0] WL_LAST = WC_W'(WR_LATENCY);
  localparam logic [RC_W-1:0] RL_LAST = RC_W'(RD_LATENCY);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_COMMIT, W_ACK} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT} r_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] data;
    logic [DM_WIDTH-1:0]   mask;
  } wr_cmd_t;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH_WORDS-1];

  // Only the word-index bits of the addresses matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr, rd_addr};

  // ---------------------------------------------------------------- refresh
  logic refreshing;
`ifdef DDR_PORT_SRAM_REFRESH_EN
  localparam int REFRESH_INTERVAL = 512;
  localparam int REFRESH_CYCLES   = 16;
  localparam int RI_W = $clog2(REFRESH_INTERVAL);
  localparam int RF_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [RI_W-1:0] REF_LAST = RI_W'(REFRESH_INTERVAL - 1);
  localparam logic [RF_W-1:0] REF_LEN  = RF_W'(REFRESH_CYCLES);

  logic [RI_W-1:0] ref_cnt;
  logic [RF_W-1:0] ref_left;

  // A refresh starts each time the free-running counter wraps.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ref_cnt  <= '0;
      ref_left <= '0;
    end else begin
      ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + RI_W'(1);
      if (ref_cnt == REF_LAST)  ref_left <= REF_LEN;
      else if (ref_left != '0)  ref_left <= ref_left - RF_W'(1);
    end
  end
  assign refreshing = (ref_left != '0);
`else
  assign refreshing = 1'b0;
`endif

  // ------------------------------------------------------------ write side
  w_state_t        w_state, w_next;
  logic [WC_W-1:0] w_cnt;
  wr_cmd_t         w_cmd;
  logic            w_cap_addr, w_cap_data, w_commit;

  always_comb begin
    w_next     = w_state;
    w_cap_addr = 1'b0;
    w_cap_data = 1'b0;
    w_commit   = 1'b0;
    case (w_state)
      W_IDLE: if (wr_addr_en && !refreshing) begin
        w_cap_addr = 1'b1;
        if (wr_en) begin
          w_cap_data = 1'b1;
          w_next     = W_COMMIT;
        end else begin
          w_next     = W_DATA;
        end
      end
      W_DATA: if (wr_en) begin
        w_cap_data = 1'b1;
        w_next     = W_COMMIT;
      end
      W_COMMIT: if (w_cnt == WL_LAST) begin
        w_commit = 1'b1;
        w_next   = W_ACK;
      end
      W_ACK:   w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
    end else begin
      w_state <= w_next;
      if (w_cap_data)               w_cnt <= WC_W'(1);
      else if (w_state == W_COMMIT) w_cnt <= w_cnt + WC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap_addr) w_cmd.idx <= wr_addr[OFF_W +: IDX_W];
    if (w_cap_data) begin
      w_cmd.data <= wr_data;
      w_cmd.mask <= wr_datamask;
    end
  end

  // Array commit happens on the edge that ends the last W_COMMIT cycle.
  always_ff @(posedge clk) begin
    if (w_commit)
      for (int b = 0; b < DM_WIDTH; b++)
        if (!w_cmd.mask[b]) mem[w_cmd.idx][b*8 +: 8] <= w_cmd.data[b*8 +: 8];
  end

  assign wr_busy = (w_state != W_IDLE) || refreshing;
  assign wr_ack  = (w_state == W_ACK);

  // ------------------------------------------------------------- read side
  r_state_t              r_state, r_next;
  logic [RC_W-1:0]       rd_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_cap_addr, r_issue;
  logic [DATA_WIDTH-1:0] rd_word, samp_q, hold_q;

  always_comb begin
    r_next     = r_state;
    r_cap_addr = 1'b0;
    r_issue    = 1'b0;
    case (r_state)
      R_IDLE: if (rd_addr_en && !refreshing) begin
        r_cap_addr = 1'b1;
        if (rd_en) begin
          r_issue = 1'b1;
          r_next  = R_WAIT;
        end else begin
          r_next  = R_ADDR;
        end
      end
      R_ADDR: if (rd_en) begin
        r_issue = 1'b1;
        r_next  = R_WAIT;
      end
      R_WAIT:  if (rd_cnt == RL_LAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= R_IDLE;
      rd_cnt  <= '0;
    end else begin
      r_state <= r_next;
      if (r_issue)                rd_cnt <= RC_ONE;
      else if (r_state == R_WAIT) rd_cnt <= rd_cnt + RC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (r_cap_addr) r_idx <= rd_addr[OFF_W +: IDX_W];
  end

  // Array read with write-first bypass: a commit to the same word in the
  // sampling cycle is merged byte-by-byte into the returned word.
  always_comb begin
    rd_word = mem[r_idx];
    for (int b = 0; b < DM_WIDTH; b++)
      if (w_commit && (w_cmd.idx == r_idx) && !w_cmd.mask[b])
        rd_word[b*8 +: 8] = w_cmd.data[b*8 +: 8];
  end

  assign rd_ack   = (r_state == R_WAIT) && (rd_cnt == RC_ONE);
  assign rd_valid = (r_state == R_WAIT) && (rd_cnt == RL_LAST);

  // The sample is taken in the rd_ack cycle; with RD_LATENCY=1 that is also
  // the rd_valid cycle, so the live read word goes straight out.
  assign rd_data = rd_valid ? (rd_ack ? rd_word : samp_q) : hold_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      samp_q <= '0;
      hold_q <= '0;
    end else begin
      if (rd_ack)   samp_q <= rd_word;
      if (rd_valid) hold_q <= rd_data;
    end
  end

  assign rd_busy = (r_state != R_IDLE) || refreshing;

endmodule

// File: tb/tb_ddr_port_sram.sv
// Scoreboard bench for ddr_port_sram (default build, no refresh).
// Stimulus tasks push expected ack/valid cycles and read descriptors into
// queues; a negedge monitor pops and compares whenever the DUT pulses.
// Reference memory: a log of committed writes (commit cycle, word, data, mask);
// a read returns the byte-wise merge of every logged write to its word that
// committed no later than the read's sampling cycle (write-first).
// Note: rst_n is active-HIGH here (rst_n=1 holds the DUT in reset).
module tb_ddr_port_sram;
  localparam int unsigned WL = 2;
  localparam int unsigned RL = 4;

  logic         clk = 0, rst_n = 1;
  logic [31:0]  wr_addr = 0, rd_addr = 0;
  logic         wr_addr_en = 0, wr_en = 0, rd_addr_en = 0, rd_en = 0;
  logic [127:0] wr_data = 0;
  logic [15:0]  wr_datamask = 0;
  logic         wr_busy, wr_ack, rd_busy, rd_ack, rd_valid;
  logic [127:0] rd_data;

  ddr_port_sram dut (
    .clk(clk), .rst_n(rst_n),
    .wr_addr(wr_addr), .wr_addr_en(wr_addr_en), .wr_data(wr_data),
    .wr_datamask(wr_datamask), .wr_en(wr_en), .wr_busy(wr_busy), .wr_ack(wr_ack),
    .rd_addr(rd_addr), .rd_addr_en(rd_addr_en), .rd_en(rd_en), .rd_busy(rd_busy),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  typedef struct { int unsigned ccyc; int idx; logic [127:0] data; logic [15:0] mask; } wlog_t;
  typedef struct { int unsigned vcyc; int idx; int unsigned scyc; } rexp_t;
  wlog_t       wlog[$];
  rexp_t       rq[$];
  int unsigned rackq[$], wackq[$];
  int unsigned wack_cnt = 0, rvalid_cnt = 0;
  logic [127:0] last_rd = '0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd1024);
  endfunction

  function automatic logic [127:0] model_read(input int idx, input int unsigned scyc);
    logic [127:0] w = '0;
    foreach (wlog[i])
      if (wlog[i].idx == idx && wlog[i].ccyc <= scyc)
        for (int b = 0; b < 16; b++)
          if (!wlog[i].mask[b]) w[b*8 +: 8] = wlog[i].data[b*8 +: 8];
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin : mon
    rexp_t        e;
    logic [127:0] x;
    if (rst_n) begin
      check("reset_flags", 128'({wr_busy, wr_ack, rd_busy, rd_ack, rd_valid}), 128'(0));
      check("reset_rd_data", rd_data, '0);
      last_rd = '0;
    end else begin
      if (wr_ack) begin
        wack_cnt++;
        if (wackq.size() == 0) bad("wr_ack_unexpected");
        else check("wr_ack_cycle", 128'(cyc), 128'(wackq.pop_front()));
      end
      if (rd_ack) begin
        if (rackq.size() == 0) bad("rd_ack_unexpected");
        else check("rd_ack_cycle", 128'(cyc), 128'(rackq.pop_front()));
      end
      if (rd_valid) begin
        rvalid_cnt++;
        if (rq.size() == 0) bad("rd_valid_unexpected");
        else begin
          e = rq.pop_front();
          x = model_read(e.idx, e.scyc);
          check("rd_valid_cycle", 128'(cyc), 128'(e.vcyc));
          check("rd_data", rd_data, x);
          last_rd = x;
        end
      end else begin
        check("rd_data_hold", rd_data, last_rd);
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr_idle();
    int n = 0;
    while (wr_busy && n < 100) begin step(); n++; end
    if (wr_busy) bad("wr_busy_timeout");
  endtask

  task automatic wait_rd_idle();
    int n = 0;
    while (rd_busy && n < 100) begin step(); n++; end
    if (rd_busy) bad("rd_busy_timeout");
  endtask

  task automatic drain();
    int n = 0;
    while ((wackq.size() != 0 || rackq.size() != 0 || rq.size() != 0) && n < 100) begin
      step(); n++;
    end
    if (wackq.size() != 0 || rackq.size() != 0 || rq.size() != 0) bad("response_timeout");
    wait_wr_idle();
    wait_rd_idle();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [127:0] data,
                          input logic [15:0] mask, input bit together, input int gap);
    int unsigned d;
    wait_wr_idle();
    wr_addr = addr; wr_addr_en = 1; wr_en = together;
    wr_data = together ? data : ~data;
    wr_datamask = together ? mask : ~mask;
    d = cyc;
    if (!together) begin
      step();
      check("wr_busy_after_addr", 128'(wr_busy), 128'(1));
      // Address strobes while waiting for data must be ignored.
      for (int g = 0; g < gap; g++) begin
        wr_addr = $urandom; wr_addr_en = 1'($urandom_range(0, 1)); wr_en = 0;
        step();
      end
      wr_addr = $urandom; wr_addr_en = 1'($urandom_range(0, 1));
      wr_en = 1; wr_data = data; wr_datamask = mask;
      d = cyc;
    end
    wlog.push_back('{d + WL, idx_of(addr), data, mask});
    wackq.push_back(d + WL + 1);
    step();
    wr_addr_en = 0; wr_en = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input bit together, input int gap);
    int unsigned i;
    wait_rd_idle();
    rd_addr = addr; rd_addr_en = 1; rd_en = together;
    if (!together) begin
      step();
      check("rd_busy_after_addr", 128'(rd_busy), 128'(1));
      rd_addr = $urandom; rd_addr_en = 0;
      repeat (gap) step();
      rd_en = 1;
    end
    i = cyc;
    rq.push_back('{i + RL, idx_of(addr), i + 1});
    rackq.push_back(i + 1);
    step();
    rd_addr_en = 0; rd_en = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a = $urandom;
    a[13:4] = 10'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    int unsigned n;
    logic [15:0] m;
    repeat (3) step();
    rst_n = 0;
    step();

    // Known contents for the words the bench touches.
    for (int w = 0; w < 16; w++) do_write(32'(w * 16), '0, '0, 1, 0);

    do_write(32'h40, 128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000, 1, 0);
    do_read(32'h40, 1, 0);
    do_write(32'h0, '1, 16'hFFFE, 1, 0);
    do_read(32'h0, 1, 0);
    do_write(32'h4010, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 0, 1);
    do_read(32'h0010, 0, 2);
    do_write(32'h48, '1, 16'hFFFF, 0, 0);      // fully masked: word 4 unchanged
    do_read(32'h4F, 1, 0);

    // Read sampling in the commit cycle sees new data; one cycle earlier, old.
    drain();
    fork
      do_write(32'h50, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 1, 0);
      begin step(); do_read(32'h50, 1, 0); end
    join
    drain();
    fork
      do_write(32'h60, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 1, 0);
      do_read(32'h60, 1, 0);
    join

    // wr_en with no captured address is ignored (no ack).
    drain();
    n = wack_cnt;
    wr_en = 1; wr_data = '1; wr_datamask = '0;
    step();
    wr_en = 0;
    repeat (6) step();
    check("wr_en_alone_no_ack", 128'(wack_cnt), 128'(n));

    // Reset while in W_COMMIT: no ack, old word kept.
    do_write(32'h30, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 16'h0000, 1, 0);
    drain();
    wr_addr = 32'h30; wr_addr_en = 1; wr_en = 1; wr_data = '1; wr_datamask = '0;
    step();
    wr_addr_en = 0; wr_en = 0;
    n = wack_cnt;
    rst_n = 1;
    step(); step();
    rst_n = 0;
    repeat (6) step();
    check("reset_in_commit_no_ack", 128'(wack_cnt), 128'(n));
    do_read(32'h30, 1, 0);

    // Reset while in R_WAIT: no rd_valid.
    drain();
    rd_addr = 32'h30; rd_addr_en = 1; rd_en = 1;
    rackq.push_back(cyc + 1);
    step();
    rd_addr_en = 0; rd_en = 0;
    step();
    n = rvalid_cnt;
    rst_n = 1;
    step();
    rst_n = 0;
    repeat (8) step();
    check("reset_in_wait_no_valid", 128'(rvalid_cnt), 128'(n));

    // Randomized mix; write and read sides overlap freely.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0:       m = 16'h0000;
          1:       m = 16'hFFFF;
          default: m = 16'($urandom);
        endcase
        do_write(rand_addr(), {$urandom, $urandom, $urandom, $urandom}, m,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end else begin
        do_read(rand_addr(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end
    end
    drain();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
